// File: rtl/wire_bridge_pkg.sv
// Shared constants and status-word helpers for the wire_bridge host/core bridge.
// The stall flag and beat counter fields are only populated when WIRE_BRIDGE_STATS_EN is defined.
package wire_bridge_pkg;

  localparam int WORD_W       = 32;
  localparam int ST_ACK       = 0;
  localparam int ST_FULL      = 1;
  localparam int ST_HEADV     = 2;
  localparam int ST_STALL     = 3;
  localparam int ST_OCC_LSB   = 8;
  localparam int ST_CNT_LSB   = 16;
  localparam int OCC_W        = 8;
  localparam int CNT_W        = 16;
  localparam int STALL_THRESH = 1024;
  localparam int STALL_W      = $clog2(STALL_THRESH) + 1;

  function automatic logic [OCC_W-1:0] sat_occ(input int unsigned n);
    if (n > (2**OCC_W - 1)) return '1;
    return OCC_W'(n);
  endfunction

  function automatic logic [WORD_W-1:0] make_status(
    input logic             ack,
    input logic             full,
    input logic             headv,
    input logic             stall,
    input logic [OCC_W-1:0] occ,
    input logic [CNT_W-1:0] cnt
  );
    logic [WORD_W-1:0] s;
    s                         = '0;
    s[ST_ACK]                 = ack;
    s[ST_FULL]                = full;
    s[ST_HEADV]               = headv;
    s[ST_STALL]               = stall;
    s[ST_OCC_LSB +: OCC_W]    = occ;
    s[ST_CNT_LSB +: CNT_W]    = cnt;
    return s;
  endfunction

endpackage

// File: rtl/wire_bridge_fifo.sv
// Synchronous FIFO with a registered head word (reads 0 when empty) plus full/empty/count.
// Pointers carry one extra wrap bit so full and empty are distinguishable without a separate flag.
module wire_bridge_fifo
  import wire_bridge_pkg::*;
#(
  parameter int  WIDTH = 32,
  parameter int  DEPTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [CW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count, count_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             do_push, do_pop;

  assign count   = wr_ptr_q - rd_ptr_q;
  assign full_o  = (count == CW'(DEPTH));
  assign empty_o = (count == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign count_o = count;
  assign head_o  = head_q;

  // The head register is preloaded from the next read slot; a push into a
  // FIFO that is (or becomes) empty bypasses the array for that one word.
  always_comb begin
    wr_ptr_d = wr_ptr_q + CW'(do_push);
    rd_ptr_d = rd_ptr_q + CW'(do_pop);
    count_d  = wr_ptr_d - rd_ptr_d;
    head_d   = mem_q[rd_ptr_d[AW-1:0]];
    if (count_d == '0) begin
      head_d = '0;
    end else if (do_push && ((count - CW'(do_pop)) == '0)) begin
      head_d = wdata_i;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      head_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      head_q   <= head_d;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end
  end

endmodule

// File: rtl/wire_bridge.sv
// FrontPanel wire-in/wire-out to ready/valid bridge using toggle-sequence handshakes, one FIFO per channel.
// Define WIRE_BRIDGE_STATS_EN to add per-channel beat counters and sticky long-stall flags to the status words.
module wire_bridge
  import wire_bridge_pkg::*;
#(
  parameter int N_IN  = 2,
  parameter int N_OUT = 1,
  parameter int W_IN  = 2,
  parameter int W_OUT = 1,
  parameter int DEPTH = 8
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic [N_IN*W_IN*WORD_W-1:0]   host_in_data,
  input  logic [N_IN-1:0]               host_in_seq,
  output logic [N_IN*WORD_W-1:0]        host_in_status,
  output logic [N_IN-1:0]               dev_in_valid,
  input  logic [N_IN-1:0]               dev_in_ready,
  output logic [N_IN*W_IN*WORD_W-1:0]   dev_in_bits,
  input  logic [N_OUT-1:0]              dev_out_valid,
  output logic [N_OUT-1:0]              dev_out_ready,
  input  logic [N_OUT*W_OUT*WORD_W-1:0] dev_out_bits,
  output logic [N_OUT*W_OUT*WORD_W-1:0] host_out_data,
  input  logic [N_OUT-1:0]              host_out_seq,
  output logic [N_OUT*WORD_W-1:0]       host_out_status
);

  localparam int IN_W  = W_IN * WORD_W;
  localparam int OUT_W = W_OUT * WORD_W;
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int N_CH  = N_IN + N_OUT;

  logic             out_en_q;
  logic [CNT_W-1:0] ch_cnt [N_CH];
  logic [N_CH-1:0]  ch_stall;

  // Holds dev_out_ready low through the reset cycle itself.
  always_ff @(posedge clock) begin
    if (!reset_n) out_en_q <= 1'b0;
    else          out_en_q <= 1'b1;
  end

`ifdef WIRE_BRIDGE_STATS_EN
  logic [N_CH-1:0] ch_pending;
  logic [N_CH-1:0] ch_serviced;

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_stats
    logic [CNT_W-1:0]   cnt_q;
    logic [STALL_W-1:0] wait_q;
    logic               stall_q;

    always_ff @(posedge clock) begin
      if (!reset_n) begin
        cnt_q   <= '0;
        wait_q  <= '0;
        stall_q <= 1'b0;
      end else begin
        if (ch_serviced[gi]) cnt_q <= cnt_q + CNT_W'(1);
        if (ch_pending[gi] && !ch_serviced[gi]) begin
          if (wait_q != STALL_W'(STALL_THRESH)) wait_q <= wait_q + STALL_W'(1);
          if (wait_q == STALL_W'(STALL_THRESH - 1)) stall_q <= 1'b1;
        end else begin
          wait_q <= '0;
        end
      end
    end

    assign ch_cnt[gi]   = cnt_q;
    assign ch_stall[gi] = stall_q;
  end
`else
  for (genvar gi = 0; gi < N_CH; gi++) begin : g_nostats
    assign ch_cnt[gi] = '0;
  end
  assign ch_stall = '0;
`endif

  for (genvar gi = 0; gi < N_IN; gi++) begin : g_in
    logic            seq_q, ack_q;
    logic [IN_W-1:0] data_q;
    logic            pending, push, full, empty;
    logic [CW-1:0]   count;

    assign pending = (seq_q != ack_q);
    assign push    = pending && !full;

    always_ff @(posedge clock) begin
      if (!reset_n) begin
        seq_q  <= 1'b0;
        ack_q  <= 1'b0;
        data_q <= '0;
      end else begin
        seq_q  <= host_in_seq[gi];
        data_q <= host_in_data[gi*IN_W +: IN_W];
        if (push) ack_q <= seq_q;
      end
    end

    wire_bridge_fifo #(.WIDTH(IN_W), .DEPTH(DEPTH)) u_fifo (
      .clock   (clock),
      .reset_n (reset_n),
      .push_i  (push),
      .wdata_i (data_q),
      .pop_i   (dev_in_ready[gi]),
      .head_o  (dev_in_bits[gi*IN_W +: IN_W]),
      .full_o  (full),
      .empty_o (empty),
      .count_o (count)
    );

    assign dev_in_valid[gi] = !empty;
    assign host_in_status[gi*WORD_W +: WORD_W] =
      make_status(ack_q, full, 1'b0, ch_stall[gi], sat_occ(32'(count)), ch_cnt[gi]);

`ifdef WIRE_BRIDGE_STATS_EN
    assign ch_pending[gi]  = pending;
    assign ch_serviced[gi] = push;
`endif
  end

  for (genvar gi = 0; gi < N_OUT; gi++) begin : g_out
    logic          seq_q, ack_q;
    logic          pending, pop, full, empty, headv;
    logic [CW-1:0] count;

    assign pending = (seq_q != ack_q);
    assign pop     = pending && !empty;
    // A head the host has already asked to pop is no longer reported as valid.
    assign headv   = !empty && !pending;

    always_ff @(posedge clock) begin
      if (!reset_n) begin
        seq_q <= 1'b0;
        ack_q <= 1'b0;
      end else begin
        seq_q <= host_out_seq[gi];
        if (pop) ack_q <= seq_q;
      end
    end

    assign dev_out_ready[gi] = out_en_q && !full;

    wire_bridge_fifo #(.WIDTH(OUT_W), .DEPTH(DEPTH)) u_fifo (
      .clock   (clock),
      .reset_n (reset_n),
      .push_i  (dev_out_valid[gi] && dev_out_ready[gi]),
      .wdata_i (dev_out_bits[gi*OUT_W +: OUT_W]),
      .pop_i   (pop),
      .head_o  (host_out_data[gi*OUT_W +: OUT_W]),
      .full_o  (full),
      .empty_o (empty),
      .count_o (count)
    );

    assign host_out_status[gi*WORD_W +: WORD_W] =
      make_status(ack_q, full, headv, ch_stall[N_IN+gi], sat_occ(32'(count)), ch_cnt[N_IN+gi]);

`ifdef WIRE_BRIDGE_STATS_EN
    assign ch_pending[N_IN+gi]  = pending;
    assign ch_serviced[N_IN+gi] = pop;
`endif
  end

endmodule

// File: tb/tb_wire_bridge.sv
// Directed bench for wire_bridge: scoreboard on in-channel 0 beats plus direct status/data checks.
`timescale 1ns/1ps
module tb_wire_bridge;

  localparam int N_IN  = 2;
  localparam int N_OUT = 1;
  localparam int W_IN  = 2;
  localparam int W_OUT = 1;
  localparam int DEPTH = 8;
`ifdef WIRE_BRIDGE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic                      clock = 1'b0;
  logic                      reset_n = 1'b0;
  logic [N_IN*W_IN*32-1:0]   host_in_data = '0;
  logic [N_IN-1:0]           host_in_seq = '0;
  logic [N_IN*32-1:0]        host_in_status;
  logic [N_IN-1:0]           dev_in_valid;
  logic [N_IN-1:0]           dev_in_ready = '0;
  logic [N_IN*W_IN*32-1:0]   dev_in_bits;
  logic [N_OUT-1:0]          dev_out_valid = '0;
  logic [N_OUT-1:0]          dev_out_ready;
  logic [N_OUT*W_OUT*32-1:0] dev_out_bits = '0;
  logic [N_OUT*W_OUT*32-1:0] host_out_data;
  logic [N_OUT-1:0]          host_out_seq = '0;
  logic [N_OUT*32-1:0]       host_out_status;

  wire_bridge #(.N_IN(N_IN), .N_OUT(N_OUT), .W_IN(W_IN), .W_OUT(W_OUT), .DEPTH(DEPTH)) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .host_in_data    (host_in_data),
    .host_in_seq     (host_in_seq),
    .host_in_status  (host_in_status),
    .dev_in_valid    (dev_in_valid),
    .dev_in_ready    (dev_in_ready),
    .dev_in_bits     (dev_in_bits),
    .dev_out_valid   (dev_out_valid),
    .dev_out_ready   (dev_out_ready),
    .dev_out_bits    (dev_out_bits),
    .host_out_data   (host_out_data),
    .host_out_seq    (host_out_seq),
    .host_out_status (host_out_status)
  );

  always #5 clock = ~clock;

  int          checks = 0;
  int          errors = 0;
  int          beats_seen = 0;
  logic [63:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, want);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  // Scoreboard monitor: every channel-0 handshake must match the oldest expected beat.
  always @(negedge clock) begin
    if (reset_n && dev_in_valid[0] && dev_in_ready[0]) begin
      beats_seen++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL in0_unexpected: got beat 0x%0h, expected none", dev_in_bits[63:0]);
      end else begin
        check("in0_beat", dev_in_bits[63:0], exp_q.pop_front());
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic host_write(input int ch, input logic [63:0] data);
    host_in_data[ch*64 +: 64] = data;
    host_in_seq[ch] = ~host_in_seq[ch];
  endtask

  task automatic wait_ack(input int ch, input string name);
    int n;
    n = 0;
    while ((host_in_status[ch*32] != host_in_seq[ch]) && (n < 20)) begin
      tick(1);
      n++;
    end
    check(name, 64'(host_in_status[ch*32]), 64'(host_in_seq[ch]));
  endtask

  function automatic logic [31:0] with_stats(input logic [31:0] base, input int cnt, input bit stall);
    logic [31:0] s;
    s = base;
    if (STATS) begin
      s[31:16] = 16'(cnt);
      s[3]     = stall;
    end
    return s;
  endfunction

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    logic [63:0] d;

    // Reset state
    tick(2);
    check("rst_in_status", host_in_status, 64'h0);
    check("rst_out_status", 64'(host_out_status), 64'h0);
    check("rst_in_valid", 64'(dev_in_valid), 64'h0);
    check("rst_out_ready", 64'(dev_out_ready), 64'h0);
    check("rst_in_bits_lo", dev_in_bits[63:0], 64'h0);
    check("rst_in_bits_hi", dev_in_bits[127:64], 64'h0);
    check("rst_out_data", 64'(host_out_data), 64'h0);
    reset_n = 1'b1;
    tick(1);
    check("ready_after_rst", 64'(dev_out_ready), 64'h1);

    // Single write
    d = {32'h80, 32'h01};
    exp_q.push_back(d);
    host_write(0, d);
    wait_ack(0, "t1_ack");
    check("t1_status", 64'(host_in_status[15:0]), 64'h0101);
    check("t1_valid", 64'(dev_in_valid[0]), 64'h1);
    check("t1_bits", dev_in_bits[63:0], d);
    tick(3);
    check("t1_valid_held", 64'(dev_in_valid[0]), 64'h1);
    dev_in_ready[0] = 1'b1;
    tick(1);
    dev_in_ready[0] = 1'b0;
    check("t1_valid_drop", 64'(dev_in_valid[0]), 64'h0);
    check("t1_beats", 64'(beats_seen), 64'd1);
    check("t1_status_empty", 64'(host_in_status[15:0]), 64'h0001);

    // Backpressure: fill, then one pending write
    for (int k = 1; k <= DEPTH; k++) begin
      d = {32'(k), 32'(k * 3 + 16)};
      exp_q.push_back(d);
      host_write(0, d);
      wait_ack(0, "t2_ack");
    end
    check("t2_full", 64'(host_in_status[15:0]), 64'h0803);
    d = {32'hDEAD_0009, 32'h0000_0009};
    exp_q.push_back(d);
    host_write(0, d);
    tick(5);
    check("t2_pending", 64'(host_in_status[15:0]), 64'h0803);
    dev_in_ready[0] = 1'b1;
    tick(1);
    dev_in_ready[0] = 1'b0;
    check("t2_after_pop", 64'(host_in_status[15:0]), 64'h0701);
    tick(1);
    check("t2_captured", 64'(host_in_status[15:0]), 64'h0802);
    dev_in_ready[0] = 1'b1;
    n = 0;
    while (exp_q.size() > 0 && n < 50) begin
      tick(1);
      n++;
    end
    dev_in_ready[0] = 1'b0;
    check("t2_drained", 64'(exp_q.size()), 64'd0);
    check("t2_status_end", 64'(host_in_status[15:0]), 64'h0000);
    check("t2_valid_end", 64'(dev_in_valid[0]), 64'h0);

    // Output drain
    dev_out_valid[0] = 1'b1;
    dev_out_bits = 32'h4;
    tick(1);
    dev_out_bits = 32'h9;
    tick(1);
    dev_out_bits = 32'h0f;
    tick(1);
    dev_out_valid[0] = 1'b0;
    check("t3_data0", 64'(host_out_data), 64'h4);
    check("t3_status0", 64'(host_out_status[15:0]), 64'h0304);
    host_out_seq[0] = 1'b1;
    tick(2);
    check("t3_data1", 64'(host_out_data), 64'h9);
    check("t3_status1", 64'(host_out_status[15:0]), 64'h0205);
    host_out_seq[0] = 1'b0;
    tick(2);
    check("t3_data2", 64'(host_out_data), 64'h0f);
    check("t3_status2", 64'(host_out_status[15:0]), 64'h0104);
    host_out_seq[0] = 1'b1;
    tick(2);
    check("t3_data3", 64'(host_out_data), 64'h0);
    check("t3_status3", 64'(host_out_status[15:0]), 64'h0001);

    // Pop pending on empty
    host_out_seq[0] = 1'b0;
    tick(3);
    check("t4_ack_held", 64'(host_out_status[15:0]), 64'h0001);
    dev_out_valid[0] = 1'b1;
    dev_out_bits = 32'h55;
    tick(1);
    dev_out_valid[0] = 1'b0;
    check("t4_arrived", 64'(host_out_status[15:0]), 64'h0101);
    tick(1);
    check("t4_popped", 64'(host_out_status[15:0]), 64'h0000);
    check("t4_data", 64'(host_out_data), 64'h0);

    // Reset with 5 beats buffered
    for (int k = 1; k <= 5; k++) begin
      d = {32'h500, 32'(k)};
      exp_q.push_back(d);
      host_write(0, d);
      wait_ack(0, "t5_ack");
    end
    check("t5_occ5", 64'(host_in_status[15:0]), 64'h0501);
    reset_n = 1'b0;
    tick(1);
    exp_q.delete();
    check("t5_rst_status", host_in_status, 64'h0);
    check("t5_rst_valid", 64'(dev_in_valid), 64'h0);
    check("t5_rst_ready", 64'(dev_out_ready), 64'h0);
    reset_n = 1'b1;
    exp_q.push_back(d);
    tick(1);
    check("t5_ready_back", 64'(dev_out_ready), 64'h1);
    tick(1);
    check("t5_recaptured", 64'(host_in_status[15:0]), 64'h0101);
    check("t5_valid", 64'(dev_in_valid[0]), 64'h1);
    dev_in_ready[0] = 1'b1;
    tick(1);
    dev_in_ready[0] = 1'b0;
    check("t5_drained", 64'(exp_q.size()), 64'd0);

    // Stats fields on channel 1 (zero when the feature is compiled out)
    for (int k = 1; k <= 3; k++) begin
      host_write(1, {32'h600, 32'(k)});
      wait_ack(1, "t6_ack");
    end
    check("t6_cnt3", 64'(host_in_status[63:32]), 64'(with_stats(32'h0000_0301, 3, 1'b0)));
    for (int k = 4; k <= DEPTH; k++) begin
      host_write(1, {32'h600, 32'(k)});
      wait_ack(1, "t6_ack");
    end
    host_write(1, {32'h600, 32'h9});
    tick(1030);
    check("t6_stall", 64'(host_in_status[63:32]), 64'(with_stats(32'h0000_0802, 8, 1'b1)));
    dev_in_ready[1] = 1'b1;
    tick(20);
    dev_in_ready[1] = 1'b0;
    check("t6_sticky", 64'(host_in_status[63:32]), 64'(with_stats(32'h0000_0001, 9, 1'b1)));
    check("t6_valid_end", 64'(dev_in_valid[1]), 64'h0);

    check("final_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
